// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared state type, default widths and depth helper for the register file
package rf_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rf_state_e;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  function automatic int rf_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/rf_init_seq.sv
// rtl/rf_init_seq.sv - zero-fill sweep sequencer; holds the register file offline until every entry is cleared
module rf_init_seq
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  output logic              ready,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(rf_depth(ADDR_W) - 1);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // clear wins in either state, so a mid-sweep clear restarts from entry 0
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = ST_INIT;
      cnt_d   = '0;
    end else if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) state_d = ST_RUN;
    end
  end

  always_comb begin
    ready     = (state_q == ST_RUN);
    init_we   = (state_q == ST_INIT);
    init_addr = cnt_q;
  end

endmodule

// File: rtl/rf_multiport.sv
// rtl/rf_multiport.sv - multiport register file: NUM_RD comb read ports, two write ports, zero-fill sweep
// Define RF_BYPASS_EN to forward same-cycle write data to matching read ports.
module rf_multiport
  import rf_pkg::*;
#(
  parameter int DATA_W  = RF_DATA_W,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int NUM_RD  = 2,
  parameter int ZERO_R0 = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en0,
  input  logic [ADDR_W-1:0]        wr_addr0,
  input  logic [DATA_W-1:0]        wr_data0,
  input  logic                     wr_en1,
  input  logic [ADDR_W-1:0]        wr_addr1,
  input  logic [DATA_W-1:0]        wr_data1,
  output logic                     ready,
  output logic                     wr_clash
);

  localparam int DEPTH = rf_depth(ADDR_W);
  localparam bit Z0    = (ZERO_R0 != 0);

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic              we0, we1;
  logic              wr_clash_q, wr_clash_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  rf_init_seq #(.ADDR_W(ADDR_W)) u_init_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .ready     (ready),
    .init_we   (init_we),
    .init_addr (init_addr)
  );

  // Port 1 owns a shared address; the clash flag ignores the r0 write mask
  always_comb begin
    we1 = ready && wr_en1 && !(Z0 && wr_addr1 == '0);
    we0 = ready && wr_en0 && !(Z0 && wr_addr0 == '0) && !(wr_en1 && wr_addr1 == wr_addr0);
    wr_clash_d = ready && wr_en0 && wr_en1 && (wr_addr0 == wr_addr1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_clash_q <= 1'b0;
    else        wr_clash_q <= wr_clash_d;
  end

  assign wr_clash = wr_clash_q;

  always_ff @(posedge clk) begin
    if (init_we) begin
      mem_q[init_addr] <= '0;
    end else begin
      if (we1) mem_q[wr_addr1] <= wr_data1;
      if (we0) mem_q[wr_addr0] <= wr_data0;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (ready && !(Z0 && rd_addr[k*ADDR_W +: ADDR_W] == '0)) begin
`ifdef RF_BYPASS_EN
        if (we1 && wr_addr1 == rd_addr[k*ADDR_W +: ADDR_W])
          rd_data[k*DATA_W +: DATA_W] = wr_data1;
        else if (we0 && wr_addr0 == rd_addr[k*ADDR_W +: ADDR_W])
          rd_data[k*DATA_W +: DATA_W] = wr_data0;
        else
          rd_data[k*DATA_W +: DATA_W] = mem_q[rd_addr[k*ADDR_W +: ADDR_W]];
`else
        rd_data[k*DATA_W +: DATA_W] = mem_q[rd_addr[k*ADDR_W +: ADDR_W]];
`endif
      end
    end
  end

endmodule
